// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: multi-cycle sequencer for the RV-subset datapath with memory stall, retire count and illegal trap
module multicycle_control_fsm #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             retire,
  output logic [CNT_W-1:0] instr_count,
  output logic             illegal,
  output logic [3:0]       state_o
);
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EXEC_R   = 4'd2,
    R_WB     = 4'd3,
    MEM_ADDR = 4'd4,
    MEM_RD   = 4'd5,
    MEM_WB   = 4'd6,
    MEM_WR   = 4'd7,
    BRANCH   = 4'd8,
    TRAP     = 4'd9
  } state_t;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_SD  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  state_t             state_q, state_d;
  logic [11:0]        ctrl_q, ctrl_d;
  logic               illegal_q, illegal_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               go, fetch_done, retire_raw;
  // Moore control word per state: {pc_src, iord, mem_read, mem_write, reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op}
  function automatic logic [11:0] decode(input state_t s);
    case (s)
      FETCH:    decode = {6'b001000, 2'b00, 2'b01, 2'b00};
      DECODE:   decode = {6'b000000, 2'b00, 2'b10, 2'b00};
      EXEC_R:   decode = {6'b000000, 2'b01, 2'b00, 2'b10};
      R_WB:     decode = {6'b000010, 6'b000000};
      MEM_ADDR: decode = {6'b000000, 2'b01, 2'b10, 2'b00};
      MEM_RD:   decode = {6'b011000, 6'b000000};
      MEM_WB:   decode = {6'b000011, 6'b000000};
      MEM_WR:   decode = {6'b010100, 6'b000000};
      BRANCH:   decode = {6'b100000, 2'b01, 2'b00, 2'b01};
      default:  decode = 12'b0;
    endcase
  endfunction
  // next state, the control word it will present, and the sticky/count updates
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:    state_d = mem_ready ? DECODE : FETCH;
      DECODE:   state_d = (opcode == OP_R) ? EXEC_R :
                          (opcode == OP_LD || opcode == OP_SD) ? MEM_ADDR :
                          (opcode == OP_BEQ) ? BRANCH : TRAP;
      EXEC_R:   state_d = R_WB;
      R_WB:     state_d = FETCH;
      MEM_ADDR: state_d = (opcode == OP_LD) ? MEM_RD : MEM_WR;
      MEM_RD:   state_d = mem_ready ? MEM_WB : MEM_RD;
      MEM_WB:   state_d = FETCH;
      MEM_WR:   state_d = mem_ready ? FETCH : MEM_WR;
      BRANCH:   state_d = FETCH;
      TRAP:     state_d = TRAP;
      default:  state_d = FETCH;
    endcase
    fetch_done = (state_q == FETCH) && mem_ready;
    retire_raw = (state_q inside {R_WB, MEM_WB, BRANCH}) || ((state_q == MEM_WR) && mem_ready);
    ctrl_d     = decode(state_d);
    illegal_d  = illegal_q | (state_d == TRAP);
    cnt_d      = cnt_q + CNT_W'(retire_raw);
  end
  // state and registered control word; reset lands in FETCH with its controls preloaded
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= FETCH;
      ctrl_q    <= decode(FETCH);
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
    end
  end
  assign go          = ~rst;
  assign {pc_src, iord, mem_read, mem_write, reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op} = go ? ctrl_q : 12'b0;
  assign ir_write    = go & fetch_done;
  assign pc_write    = go & (fetch_done | ((state_q == BRANCH) & zero));
  assign retire      = go & retire_raw;
  assign instr_count = go ? cnt_q : '0;
  assign illegal     = go & illegal_q;
  assign state_o     = go ? state_q : 4'd0;
endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
Multi-cycle sequencer for the RV-subset datapath (R-type ADD/SUB/AND/OR, LD, SD, BEQ), replacing single-cycle opcode decode with a state machine.
- Steps the shared ALU, register file and single unified memory through fetch, decode, execute, memory and writeback.
- Stalls on a memory-ready handshake.
- Counts retired instructions and traps on illegal opcodes.

Parameters:
CNT_W, 16, width of retired-instruction counter.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
opcode  input  7  IR[6:0]; stable from DECODE until the next FETCH
zero  input  1  ALU zero flag, valid in BRANCH
mem_ready  input  1  memory completes the current read/write this cycle
ir_write  output  1  load IR from memory read data
pc_write  output  1  load PC
pc_src  output  1  0: PC<=ALU result, 1: PC<=ALUOut (branch target)
iord  output  1  memory address select, 0: PC, 1: ALUOut
mem_read  output  1  memory read request
mem_write  output  1  memory write request
reg_write  output  1  register file write enable
mem_to_reg  output  1  writeback select, 0: ALUOut, 1: MDR
alu_src_a  output  2  00: PC, 01: rs1
alu_src_b  output  2  00: rs2, 01: constant 4, 10: immediate
alu_op  output  2  00: add, 01: subtract (compare), 10: funct decode
retire  output  1  one-cycle pulse when an instruction completes
instr_count  output  CNT_W  retired instruction count
illegal  output  1  sticky illegal-opcode flag
state_o  output  4  current state encoding, for debug

Behaviour:
- Reset:
  - State FETCH, instr_count=0, illegal=0.
  - While rst=1 all outputs are 0; state_o=0.
  - Reset asserted mid-instruction aborts it with no retire.
- Outputs are a Moore decode of the state, except where noted; any output not listed for a state is 0.
- State encodings: FETCH=0, DECODE=1, EXEC_R=2, R_WB=3, MEM_ADDR=4, MEM_RD=5, MEM_WB=6, MEM_WR=7, BRANCH=8, TRAP=9.
- FETCH:
  - Outputs: mem_read=1, iord=0, alu_src_a=00, alu_src_b=01, alu_op=00.
  - ir_write and pc_write are 1 only in the cycle mem_ready=1 (Mealy).
  - mem_ready=1: go to DECODE. Otherwise stay.
- DECODE:
  - Outputs: alu_src_a=00, alu_src_b=10, alu_op=00 (branch target into ALUOut).
  - Next state by opcode:
    - 0110011 -> EXEC_R
    - 0000011 or 0100011 -> MEM_ADDR
    - 1100011 -> BRANCH
    - any other -> TRAP
- EXEC_R: alu_src_a=01, alu_src_b=00, alu_op=10 -> R_WB.
- R_WB: reg_write=1, mem_to_reg=0, retire=1 -> FETCH.
- MEM_ADDR: alu_src_a=01, alu_src_b=10, alu_op=00 -> MEM_RD if opcode=0000011, else MEM_WR.
- MEM_RD: mem_read=1, iord=1; stay until mem_ready=1, then go to MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, retire=1 -> FETCH.
- MEM_WR:
  - mem_write=1, iord=1.
  - retire=1 only in the mem_ready=1 cycle (Mealy), then go to FETCH; otherwise hold.
- BRANCH:
  - alu_src_a=01, alu_src_b=00, alu_op=01, pc_src=1.
  - pc_write=zero (Mealy).
  - retire=1 -> FETCH.
- TRAP: illegal<=1; all enables 0. Terminal until reset; no retire.
- mem_ready outside FETCH/MEM_RD/MEM_WR is ignored.
- mem_read and mem_write are never both 1.
- Latencies with zero-wait memory: R-type 4 cycles, BEQ 3, LD 5, SD 4. Each wait cycle adds one.
- instr_count increments on the clock edge ending a retire cycle; wraps from 2^CNT_W-1 to 0.

Test Plan:
- Reset, then opcode=0110011 with mem_ready tied 1 -> state sequence 0,1,2,3,0. reg_write=1 only in state 3. retire pulses once; instr_count=1.
- LD (0000011), mem_ready low for 2 cycles in FETCH and 3 in MEM_RD -> 10 cycles total. ir_write pulses once. mem_to_reg=1 with reg_write in MEM_WB; instr_count=1.
- SD (0100011) -> mem_write=1, iord=1 in MEM_WR; reg_write never 1; retire coincides with mem_ready.
- BEQ with zero=1, then with zero=0 -> pc_write=1 with pc_src=1 in BRANCH only in the first case. Both cases retire.
- Illegal opcode 1111111 -> TRAP, illegal=1 sticky for 20 cycles; instr_count unchanged. rst pulse then clears it to FETCH.
- CNT_W=4, 16 back-to-back R-type instructions -> instr_count wraps 15->0. Asserting rst in MEM_RD returns state_o=0 with no retire.
